wb_mem_arbiter: RTL and testbench

WB_MEM_ARBITER -- requirements
Module: wb_mem_arbiter

---
 rtl/wb_arb_pkg.sv | 18 +
 rtl/wb_range_check.sv | 11 +
 rtl/wb_mem_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_wb_mem_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone memory arbiter.
package wb_arb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_M0 = 3'd1,
        WAIT_M1 = 3'd2,
        ERR_M0  = 3'd3,
        ERR_M1  = 3'd4
    } arb_state_e;

    localparam int M_INST = 0;
    localparam int M_DATA = 1;

    localparam logic [31:0] DEF_ADR_BEGIN = 32'h0000_0000;
    localparam logic [31:0] DEF_ADR_END   = 32'h0000_7FFF;

endpackage

// File: rtl/wb_range_check.sv
// Combinational inclusive address window test used to decide whether a grant reaches the slave.
module wb_range_check (
    input  logic [31:0] adr,
    input  logic [31:0] adr_begin,
    input  logic [31:0] adr_end,
    output logic        hit
);

    assign hit = (adr >= adr_begin) && (adr <= adr_end);

endmodule

// File: rtl/wb_mem_arbiter.sv
// Instruction/data master to single-slave pipelined Wishbone arbiter, one transfer outstanding.
// Define WB_ARB_RR_EN for round-robin tie breaking; the default build gives the data master priority.
module wb_mem_arbiter
    import wb_arb_pkg::*;
#(
    parameter logic [31:0] ADR_BEGIN = DEF_ADR_BEGIN,
    parameter logic [31:0] ADR_END   = DEF_ADR_END
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    output logic        m0_stall_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic [31:0] m0_dat_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    output logic        m1_stall_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [31:0] m1_dat_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    input  logic        s_stall_i,
    input  logic        s_ack_i,
    input  logic        s_err_i,
    input  logic [31:0] s_dat_i
);

    arb_state_e  state_q, state_d;
    logic        hold_q, hold_d;
    logic        hold_idx_q, hold_idx_d;
`ifdef WB_ARB_RR_EN
    logic        last_q, last_d;
`endif

    logic [1:0]  req;
    logic        grant;
    logic        owner;
    logic        owner_cyc;
    logic        hit;
    logic        g_we;
    logic [31:0] g_adr;
    logic [31:0] g_dat;
    logic [3:0]  g_sel;

    logic [1:0]  stall_c, ack_c, err_c;
    logic        s_cyc_c, s_stb_c, s_we_c;
    logic [31:0] s_adr_c, s_dat_c;
    logic [3:0]  s_sel_c;

    assign req[M_INST] = m0_cyc_i & m0_stb_i;
    assign req[M_DATA] = m1_cyc_i & m1_stb_i;

    assign g_we  = grant ? m1_we_i  : m0_we_i;
    assign g_adr = grant ? m1_adr_i : m0_adr_i;
    assign g_dat = grant ? m1_dat_i : m0_dat_i;
    assign g_sel = grant ? m1_sel_i : m0_sel_i;

    assign owner     = (state_q == WAIT_M1);
    assign owner_cyc = owner ? m1_cyc_i : m0_cyc_i;

    wb_range_check u_range (
        .adr       (g_adr),
        .adr_begin (ADR_BEGIN),
        .adr_end   (ADR_END),
        .hit       (hit)
    );

    // A stalled grant keeps ownership so the slave sees a stable request until it is taken.
    always_comb begin
        grant = req[M_DATA];
        if (hold_q && req[hold_idx_q]) begin
            grant = hold_idx_q;
        end else if (&req) begin
`ifdef WB_ARB_RR_EN
            grant = ~last_q;
`else
            grant = 1'b1;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_d     = 1'b0;
        hold_idx_d = hold_idx_q;
`ifdef WB_ARB_RR_EN
        last_d     = last_q;
`endif
        stall_c = 2'b00;
        ack_c   = 2'b00;
        err_c   = 2'b00;
        s_cyc_c = 1'b0;
        s_stb_c = 1'b0;
        s_we_c  = 1'b0;
        s_adr_c = '0;
        s_dat_c = '0;
        s_sel_c = '0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    stall_c[~grant] = 1'b1;
                    if (hit) begin
                        s_cyc_c = 1'b1;
                        s_stb_c = 1'b1;
                        s_we_c  = g_we;
                        s_adr_c = g_adr;
                        s_dat_c = g_dat;
                        s_sel_c = g_sel;
                        stall_c[grant] = s_stall_i;
                        if (s_stall_i) begin
                            hold_d     = 1'b1;
                            hold_idx_d = grant;
                        end else begin
                            state_d = grant ? WAIT_M1 : WAIT_M0;
`ifdef WB_ARB_RR_EN
                            last_d  = grant;
`endif
                        end
                    end else begin
                        // Out-of-window requests are swallowed here and answered with an error.
                        state_d = grant ? ERR_M1 : ERR_M0;
`ifdef WB_ARB_RR_EN
                        last_d  = grant;
`endif
                    end
                end
            end
            WAIT_M0, WAIT_M1: begin
                stall_c = 2'b11;
                s_cyc_c = owner_cyc;
                if (!owner_cyc) begin
                    state_d = IDLE;
                end else begin
                    ack_c[owner] = s_ack_i;
                    err_c[owner] = s_err_i;
                    if (s_ack_i || s_err_i) begin
                        state_d = IDLE;
                    end
                end
            end
            ERR_M0: begin
                stall_c       = 2'b11;
                err_c[M_INST] = 1'b1;
                state_d       = IDLE;
            end
            ERR_M1: begin
                stall_c       = 2'b11;
                err_c[M_DATA] = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            hold_q     <= 1'b0;
            hold_idx_q <= 1'b0;
`ifdef WB_ARB_RR_EN
            last_q     <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            hold_idx_q <= hold_idx_d;
`ifdef WB_ARB_RR_EN
            last_q     <= last_d;
`endif
        end
    end

    // Reset forces every output low without waiting for a clock edge.
    assign m0_stall_o = ~wb_rst_i & stall_c[M_INST];
    assign m0_ack_o   = ~wb_rst_i & ack_c[M_INST];
    assign m0_err_o   = ~wb_rst_i & err_c[M_INST];
    assign m0_dat_o   = (~wb_rst_i & ack_c[M_INST]) ? s_dat_i : '0;
    assign m1_stall_o = ~wb_rst_i & stall_c[M_DATA];
    assign m1_ack_o   = ~wb_rst_i & ack_c[M_DATA];
    assign m1_err_o   = ~wb_rst_i & err_c[M_DATA];
    assign m1_dat_o   = (~wb_rst_i & ack_c[M_DATA]) ? s_dat_i : '0;
    assign s_cyc_o    = ~wb_rst_i & s_cyc_c;
    assign s_stb_o    = ~wb_rst_i & s_stb_c;
    assign s_we_o     = ~wb_rst_i & s_we_c;
    assign s_adr_o    = wb_rst_i ? '0 : s_adr_c;
    assign s_dat_o    = wb_rst_i ? '0 : s_dat_c;
    assign s_sel_o    = wb_rst_i ? '0 : s_sel_c;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Self-checking bench for wb_mem_arbiter: directed scenarios followed by random traffic, all
// checked every cycle against a transaction-level model (honours WB_ARB_RR_EN).
module tb_wb_mem_arbiter;

    localparam logic [31:0] WIN_LO = 32'h0000_0000;
    localparam logic [31:0] WIN_HI = 32'h0000_7FFF;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic [1:0]  m_cyc, m_stb, m_we;
    logic [31:0] m_adr  [2];
    logic [31:0] m_wdat [2];
    logic [3:0]  m_sel  [2];
    logic        s_stall, s_ack, s_err;
    logic [31:0] s_rdat;

    logic        m0_stall_o, m0_ack_o, m0_err_o;
    logic [31:0] m0_dat_o;
    logic        m1_stall_o, m1_ack_o, m1_err_o;
    logic [31:0] m1_dat_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [3:0]  s_sel_o;

    int checks;
    int failures;
    int cyc_no;

    // Model: who waits for a slave reply, who is owed an error, last accepted master, held grant.
    int mdl_owner, mdl_err, mdl_last, mdl_held;
    int nxt_owner, nxt_err, nxt_last, nxt_held;

    wb_mem_arbiter dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .m0_cyc_i   (m_cyc[0]),
        .m0_stb_i   (m_stb[0]),
        .m0_we_i    (m_we[0]),
        .m0_adr_i   (m_adr[0]),
        .m0_dat_i   (m_wdat[0]),
        .m0_sel_i   (m_sel[0]),
        .m0_stall_o (m0_stall_o),
        .m0_ack_o   (m0_ack_o),
        .m0_err_o   (m0_err_o),
        .m0_dat_o   (m0_dat_o),
        .m1_cyc_i   (m_cyc[1]),
        .m1_stb_i   (m_stb[1]),
        .m1_we_i    (m_we[1]),
        .m1_adr_i   (m_adr[1]),
        .m1_dat_i   (m_wdat[1]),
        .m1_sel_i   (m_sel[1]),
        .m1_stall_o (m1_stall_o),
        .m1_ack_o   (m1_ack_o),
        .m1_err_o   (m1_err_o),
        .m1_dat_o   (m1_dat_o),
        .s_cyc_o    (s_cyc_o),
        .s_stb_o    (s_stb_o),
        .s_we_o     (s_we_o),
        .s_adr_o    (s_adr_o),
        .s_dat_o    (s_dat_o),
        .s_sel_o    (s_sel_o),
        .s_stall_i  (s_stall),
        .s_ack_i    (s_ack),
        .s_err_i    (s_err),
        .s_dat_i    (s_rdat)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s cycle=%0d observed=0x%0h expected=0x%0h", tag, cyc_no, obs, exp);
        end
    endtask

    task automatic idleInputs();
        m_cyc = 2'b00;
        m_stb = 2'b00;
        m_we  = 2'b00;
        for (int m = 0; m < 2; m++) begin
            m_adr[m]  = 32'h0;
            m_wdat[m] = 32'h0;
            m_sel[m]  = 4'h0;
        end
        s_stall = 1'b0;
        s_ack   = 1'b0;
        s_err   = 1'b0;
        s_rdat  = 32'h0;
    endtask

    // Waits for the falling edge and compares every output with the model's prediction.
    task automatic checkOutput();
        logic [1:0]  e_stall, e_ack, e_err, req;
        logic [31:0] e_dat [2];
        logic        e_scyc, e_sstb;
        int          g;
        @(negedge wb_clk_i);
        e_stall = 2'b00; e_ack = 2'b00; e_err = 2'b00;
        e_dat[0] = 32'h0; e_dat[1] = 32'h0;
        e_scyc = 1'b0; e_sstb = 1'b0;
        g = -1;
        nxt_owner = mdl_owner; nxt_err = -1; nxt_last = mdl_last; nxt_held = -1;
        req = m_cyc & m_stb;
        if (wb_rst_i) begin
            nxt_owner = -1;
            nxt_last  = 1;
        end else if (mdl_err >= 0) begin
            e_stall = 2'b11;
            e_err[mdl_err] = 1'b1;
        end else if (mdl_owner >= 0) begin
            e_stall = 2'b11;
            nxt_owner = -1;
            if (m_cyc[mdl_owner]) begin
                e_scyc = 1'b1;
                e_ack[mdl_owner] = s_ack;
                e_err[mdl_owner] = s_err;
                if (s_ack) e_dat[mdl_owner] = s_rdat;
                if (!s_ack && !s_err) nxt_owner = mdl_owner;
            end
        end else if (req != 2'b00) begin
            if (mdl_held >= 0 && req[mdl_held]) begin
                g = mdl_held;
            end else if (req == 2'b11) begin
`ifdef WB_ARB_RR_EN
                g = 1 - mdl_last;
`else
                g = 1;
`endif
            end else begin
                g = req[1] ? 1 : 0;
            end
            e_stall[1-g] = 1'b1;
            if (m_adr[g] >= WIN_LO && m_adr[g] <= WIN_HI) begin
                e_scyc = 1'b1;
                e_sstb = 1'b1;
                e_stall[g] = s_stall;
                if (s_stall) begin
                    nxt_held = g;
                end else begin
                    nxt_owner = g;
                    nxt_last  = g;
                end
            end else begin
                nxt_err  = g;
                nxt_last = g;
            end
        end
        check("m0_stall", m0_stall_o, e_stall[0]);
        check("m1_stall", m1_stall_o, e_stall[1]);
        check("m0_ack",   m0_ack_o,   e_ack[0]);
        check("m1_ack",   m1_ack_o,   e_ack[1]);
        check("m0_err",   m0_err_o,   e_err[0]);
        check("m1_err",   m1_err_o,   e_err[1]);
        check("m0_dat",   m0_dat_o,   e_dat[0]);
        check("m1_dat",   m1_dat_o,   e_dat[1]);
        check("s_cyc",    s_cyc_o,    e_scyc);
        check("s_stb",    s_stb_o,    e_sstb);
        if (e_sstb) begin
            check("s_we",  s_we_o,  m_we[g]);
            check("s_adr", s_adr_o, m_adr[g]);
            check("s_dat", s_dat_o, m_wdat[g]);
            check("s_sel", s_sel_o, m_sel[g]);
        end
    endtask

    // Clocks the current inputs into the DUT and advances the model to match.
    task automatic applyStimulus();
        @(posedge wb_clk_i);
        mdl_owner = nxt_owner;
        mdl_err   = nxt_err;
        mdl_last  = nxt_last;
        mdl_held  = nxt_held;
        cyc_no++;
        #1;
    endtask

    task automatic tick();
        checkOutput();
        applyStimulus();
    endtask

    function automatic logic [31:0] pickAdr();
        case ($urandom_range(0, 5))
            0:       return WIN_LO;
            1:       return WIN_HI;
            2:       return WIN_HI + 32'h1;
            3:       return 32'hFFFF_FFFF;
            4:       return $urandom;
            default: return $urandom_range(0, 32'h7FFF);
        endcase
    endfunction

    initial begin
        checks = 0; failures = 0; cyc_no = 0;
        mdl_owner = -1; mdl_err = -1; mdl_last = 1; mdl_held = -1;
        idleInputs();

        // Reset with both masters requesting: everything must stay low.
        wb_rst_i = 1'b1;
        m_cyc = 2'b11; m_stb = 2'b11; m_adr[0] = 32'h10; m_adr[1] = 32'h20;
        #1;
        checkOutput();
        check("rst_s_cyc", s_cyc_o, 0);
        check("rst_m1_stall", m1_stall_o, 0);
        applyStimulus();
        tick();
        idleInputs();
        wb_rst_i = 1'b0;
        checkOutput();
        check("idle_m0_stall", m0_stall_o, 0);
        applyStimulus();

        // Instruction read of 0x10, slave answers DEADBEEF on the following cycle.
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h0000_0010; m_sel[0] = 4'hF;
        checkOutput();
        check("r31_stb", s_stb_o, 1);
        check("r31_adr", s_adr_o, 32'h0000_0010);
        applyStimulus();
        m_stb[0] = 1'b0; s_ack = 1'b1; s_rdat = 32'hDEAD_BEEF;
        checkOutput();
        check("r31_ack", m0_ack_o, 1);
        check("r31_dat", m0_dat_o, 32'hDEAD_BEEF);
        check("r31_m1_ack", m1_ack_o, 0);
        check("r31_m1_dat", m1_dat_o, 0);
        applyStimulus();
        idleInputs();
        tick();

        // Simultaneous requests: data master first, instruction master right after.
        m_cyc = 2'b11; m_stb = 2'b11; m_we = 2'b10;
        m_adr[0] = 32'h100; m_adr[1] = 32'h200; m_wdat[1] = 32'hCAFE_0001; m_sel[1] = 4'h3;
        checkOutput();
        check("r32_first_adr", s_adr_o, 32'h200);
        check("r32_m0_stalled", m0_stall_o, 1);
        check("r32_m1_go", m1_stall_o, 0);
        applyStimulus();
        m_stb[1] = 1'b0; s_ack = 1'b1; s_rdat = $urandom;
        checkOutput();
        check("r32_m1_ack", m1_ack_o, 1);
        check("r32_m0_wait", m0_stall_o, 1);
        applyStimulus();
        m_cyc[1] = 1'b0; s_ack = 1'b0;
        checkOutput();
        check("r32_second_adr", s_adr_o, 32'h100);
        check("r32_m0_go", m0_stall_o, 0);
        applyStimulus();
        m_stb[0] = 1'b0; s_ack = 1'b1; s_rdat = $urandom;
        checkOutput();
        check("r32_m0_ack", m0_ack_o, 1);
        applyStimulus();
        idleInputs();
        tick();

        // Highest in-window address is forwarded.
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = WIN_HI;
        checkOutput();
        check("edge_hi_stb", s_stb_o, 1);
        applyStimulus();
        m_stb[0] = 1'b0; s_ack = 1'b1;
        tick();
        idleInputs();

        // Data write just past the window: error, nothing forwarded, back to idle.
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1; m_adr[1] = 32'h0000_8000;
        checkOutput();
        check("r34_stb", s_stb_o, 0);
        check("r34_accept", m1_stall_o, 0);
        applyStimulus();
        m_stb[1] = 1'b0;
        checkOutput();
        check("r34_err", m1_err_o, 1);
        check("r34_no_stb", s_stb_o, 0);
        applyStimulus();
        m_cyc[1] = 1'b0; s_ack = 1'b1;
        checkOutput();
        check("r34_err_once", m1_err_o, 0);
        check("r34_idle", m1_stall_o, 0);
        check("r23_stray_ack", m1_ack_o, 0);
        applyStimulus();
        idleInputs();

        // Slave stalls a data request three cycles; the instruction master joins mid-stall.
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[1] = 32'h0000_4444; s_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h0000_1111;
            end
            checkOutput();
            check("r35_stall", m1_stall_o, 1);
            check("r35_adr", s_adr_o, 32'h0000_4444);
            applyStimulus();
        end
        s_stall = 1'b0;
        checkOutput();
        check("r35_accept", m1_stall_o, 0);
        check("r35_adr_acc", s_adr_o, 32'h0000_4444);
        applyStimulus();
        m_stb[1] = 1'b0; s_ack = 1'b1; s_rdat = $urandom;
        checkOutput();
        check("r35_ack", m1_ack_o, 1);
        applyStimulus();
        m_cyc[1] = 1'b0; s_ack = 1'b0;
        checkOutput();
        check("r35_m0_next", s_adr_o, 32'h0000_1111);
        applyStimulus();
        m_stb[0] = 1'b0; s_ack = 1'b1;
        tick();
        idleInputs();
        tick();

        // Reset while the instruction master waits: outputs drop at once, no late ack.
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h0000_0020;
        tick();
        m_stb[0] = 1'b0;
        wb_rst_i = 1'b1;
        #1;
        check("r36_async_cyc", s_cyc_o, 0);
        check("r36_async_stall", m1_stall_o, 0);
        tick();
        wb_rst_i = 1'b0; s_ack = 1'b1; s_rdat = 32'h1234_5678;
        checkOutput();
        check("r36_no_ack", m0_ack_o, 0);
        applyStimulus();
        idleInputs();
        tick();

        // Both masters request back to back for eight transfers.
        m_cyc = 2'b11; m_stb = 2'b11; m_adr[0] = 32'h100; m_adr[1] = 32'h200; s_ack = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s_rdat = $urandom;
            checkOutput();
            if (i % 2 == 0) begin
`ifdef WB_ARB_RR_EN
                check($sformatf("r33_grant%0d", i / 2), s_adr_o, ((i / 2) % 2 == 1) ? 32'h200 : 32'h100);
`else
                check($sformatf("r22_grant%0d", i / 2), s_adr_o, 32'h200);
`endif
            end
            applyStimulus();
        end
        idleInputs();
        tick();

        // Data master abandons its cycle while waiting: the ack must go nowhere.
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[1] = 32'h0000_0300;
        tick();
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0; s_ack = 1'b1;
        checkOutput();
        check("r21_s_cyc", s_cyc_o, 0);
        check("r21_no_ack", m1_ack_o, 0);
        applyStimulus();
        s_ack = 1'b0;
        tick();

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            wb_rst_i = ($urandom_range(0, 99) == 0);
            for (int m = 0; m < 2; m++) begin
                m_cyc[m]  = ($urandom_range(0, 9) != 0);
                m_stb[m]  = 1'($urandom_range(0, 1));
                m_we[m]   = 1'($urandom_range(0, 1));
                m_adr[m]  = pickAdr();
                m_wdat[m] = $urandom;
                m_sel[m]  = 4'($urandom_range(0, 15));
            end
            s_stall = ($urandom_range(0, 3) == 0);
            s_ack   = 1'($urandom_range(0, 1));
            s_err   = ($urandom_range(0, 7) == 0);
            s_rdat  = $urandom;
            tick();
        end
        wb_rst_i = 1'b0;
        idleInputs();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
